// File: rtl/b10_link_pkg.sv
// Shared types and sizing for the b10 link receiver: handshake FSM states
// and FIFO/counter widths.
package b10_link_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int DATA_W     = 4;
  localparam int CNT_W      = 8;
  localparam int PTR_W      = 2;
  localparam int OCC_W      = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    ACK        = 2'd2
  } state_t;

endpackage

// File: rtl/b10_link_fifo.sv
// 4-deep first-word fall-through FIFO. A pop on a full FIFO frees the slot
// for a push on the same edge; a pop on an empty FIFO is ignored.
module b10_link_fifo
  import b10_link_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [OCC_W-1:0]  count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (occ == '0);
  assign full    = (occ == OCC_W'(FIFO_DEPTH));
  assign count   = occ;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to zero while empty so stale storage never reaches the port.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the occupancy flush and rd_data gating make it invisible.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/b10_link_rx.sv
// Receive side of the b10 link: 4-phase cts/rtr handshake into a small FIFO,
// with an accepted-word counter and a sticky protocol-violation flag.
module b10_link_rx
  import b10_link_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cts,
  input  logic [DATA_W-1:0] v_data,
  output logic              rtr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [OCC_W-1:0]  count,
  output logic [CNT_W-1:0]  rx_words,
  output logic              proto_err
);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] hold;
  logic              hold_load;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              err_set;
  logic              fifo_full;
  logic              space;

  // A pop on a full FIFO retires first, so it counts as space this cycle.
  assign space = !fifo_full || rd_en;
  assign full  = fifo_full;
  assign rtr   = (state == ACK);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      hold      <= '0;
      rx_words  <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= next_state;
      if (hold_load) hold      <= v_data;
      if (push)      rx_words  <= rx_words + CNT_W'(1);
      if (err_set)   proto_err <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    hold_load  = 1'b0;
    push       = 1'b0;
    push_data  = v_data;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cts) begin
          if (space) begin
            push       = 1'b1;
            next_state = ACK;
          end else begin
            hold_load  = 1'b1;
            next_state = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        push_data = hold;
        if (!cts) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end else begin
          if (v_data != hold) err_set = 1'b1;
          if (space) begin
            push       = 1'b1;
            next_state = ACK;
          end
        end
      end
      ACK: begin
        if (!cts) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  b10_link_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (fifo_full),
    .count     (count)
  );

endmodule

// File: tb/tb_b10_link_rx.sv
// Self-checking bench for b10_link_rx: directed handshake scenarios followed by
// randomized upstream/consumer traffic, all compared against a queue-based model.
module tb_b10_link_rx;

  logic       clock;
  logic       reset;
  logic       cts;
  logic [3:0] v_data;
  logic       rtr;
  logic       rd_en;
  logic [3:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic [7:0] rx_words;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  // Reference model: a word queue plus the handshake phase seen by upstream.
  logic [3:0] mq[$];
  bit         m_acked;
  bit         m_waiting;
  logic [3:0] m_hold;
  int         m_words;
  bit         m_err;

  b10_link_rx dut (
    .clock     (clock),
    .reset     (reset),
    .cts       (cts),
    .v_data    (v_data),
    .rtr       (rtr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .rx_words  (rx_words),
    .proto_err (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit         pop_ok;
    bit         space;
    bit         do_push;
    logic [3:0] pw;
    if (!reset) begin
      mq.delete();
      m_acked   = 0;
      m_waiting = 0;
      m_hold    = '0;
      m_words   = 0;
      m_err     = 0;
      return;
    end
    pop_ok  = rd_en && (mq.size() > 0);
    space   = (mq.size() < 4) || pop_ok;
    do_push = 0;
    pw      = v_data;
    if (m_acked) begin
      if (!cts) m_acked = 0;
    end else if (m_waiting) begin
      if (!cts) begin
        m_err     = 1;
        m_waiting = 0;
      end else begin
        if (v_data != m_hold) m_err = 1;
        if (space) begin
          do_push   = 1;
          pw        = m_hold;
          m_waiting = 0;
          m_acked   = 1;
        end
      end
    end else if (cts) begin
      if (space) begin
        do_push = 1;
        m_acked = 1;
      end else begin
        m_waiting = 1;
        m_hold    = v_data;
      end
    end
    if (pop_ok) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back(pw);
      m_words = (m_words + 1) % 256;
    end
  endtask

  task automatic compare_all();
    check("rtr",       rtr,       m_acked);
    check("empty",     empty,     mq.size() == 0);
    check("full",      full,      mq.size() == 4);
    check("count",     count,     mq.size());
    check("rd_data",   rd_data,   (mq.size() > 0) ? mq[0] : 4'h0);
    check("rx_words",  rx_words,  m_words);
    check("proto_err", proto_err, m_err);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare on the falling edge.
  task automatic cycle(input bit c, input logic [3:0] v, input bit r, input bit rs);
    cts    = c;
    v_data = v;
    rd_en  = r;
    reset  = rs;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic handshake(input logic [3:0] w);
    cycle(1, w, 0, 1);
    cycle(0, w, 0, 1);
  endtask

  task automatic do_reset();
    cycle(0, 4'h0, 0, 0);
    cycle(0, 4'h0, 0, 1);
  endtask

  bit         up_req;
  logic [3:0] up_data;
  bit         rst_now;

  initial begin
    cts = 0; v_data = '0; rd_en = 0; reset = 0;
    do_reset();
    check("rst_empty", empty, 1'b1);
    check("rst_rdata", rd_data, 4'h0);

    // Single transfer from empty.
    cycle(1, 4'hA, 0, 1);
    check("single_rtr", rtr, 1'b1);
    check("single_rdata", rd_data, 4'hA);
    check("single_words", rx_words, 8'd1);
    cycle(1, 4'hA, 0, 1);
    check("single_one_push", count, 3'd1);
    cycle(0, 4'hA, 0, 1);
    check("single_rtr_drop", rtr, 1'b0);

    // Fill with 1..5: fifth word waits for space, a pop lets it in.
    do_reset();
    for (int i = 1; i <= 4; i++) handshake(4'(i));
    check("fill_full", full, 1'b1);
    cycle(1, 4'h5, 0, 1);
    cycle(1, 4'h5, 0, 1);
    check("fill_wait_rtr", rtr, 1'b0);
    cycle(1, 4'h5, 1, 1);
    check("fill_push_rtr", rtr, 1'b1);
    check("fill_count", count, 3'd4);
    check("fill_head", rd_data, 4'h2);
    cycle(0, 4'h5, 0, 1);

    // Withdrawal while waiting for space.
    do_reset();
    for (int i = 0; i < 4; i++) handshake(4'(i + 8));
    cycle(1, 4'h9, 0, 1);
    cycle(0, 4'h9, 0, 1);
    check("withdraw_err", proto_err, 1'b1);
    check("withdraw_count", count, 3'd4);
    check("withdraw_words", rx_words, 8'd4);

    // Data change while waiting: held word is still the one pushed.
    do_reset();
    for (int i = 0; i < 4; i++) handshake(4'(i + 12));
    cycle(1, 4'h3, 0, 1);
    cycle(1, 4'h7, 0, 1);
    check("change_err", proto_err, 1'b1);
    cycle(1, 4'h7, 1, 1);
    cycle(0, 4'h7, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 4'h0, 1, 1);
    check("change_held", rd_data, 4'h3);

    // Simultaneous push and pop on a full FIFO from IDLE.
    do_reset();
    for (int i = 1; i <= 4; i++) handshake(4'(i));
    cycle(1, 4'h6, 1, 1);
    check("pp_count", count, 3'd4);
    check("pp_head", rd_data, 4'h2);
    check("pp_rtr", rtr, 1'b1);
    check("pp_err", proto_err, 1'b0);
    cycle(0, 4'h6, 0, 1);

    // 256 handshakes wrap the word counter; then reset during ACK.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(1, 4'($urandom), 1, 1);
      cycle(0, 4'h0, 1, 1);
    end
    check("wrap_words", rx_words, 8'd0);
    cycle(1, 4'hB, 0, 1);
    cycle(1, 4'hB, 0, 0);
    check("rst_ack_rtr", rtr, 1'b0);
    check("rst_ack_empty", empty, 1'b1);
    check("rst_ack_err", proto_err, 1'b0);
    cycle(0, 4'h0, 0, 1);

    // Randomized traffic: mostly well-behaved upstream with occasional violations.
    up_req  = 0;
    up_data = '0;
    for (int n = 0; n < 4000; n++) begin
      rst_now = ($urandom_range(0, 299) == 0);
      if (rst_now) begin
        up_req = 0;
      end else if (!up_req) begin
        if ($urandom_range(0, 2) == 0) begin
          up_req  = 1;
          up_data = 4'($urandom);
        end
      end else if (m_acked) begin
        if ($urandom_range(0, 1) == 0) up_req = 0;
      end else if (m_waiting) begin
        case ($urandom_range(0, 59))
          0:       up_req  = 0;
          1:       up_data = 4'($urandom);
          default: ;
        endcase
      end
      cycle(up_req, up_data, ($urandom_range(0, 99) < ((n / 500) % 2 ? 15 : 45)), !rst_now);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b10_link_rx.md
B10_LINK_RX -- requirements
Module: b10_link_rx

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset, sampled on rising clock edge.
REQ-003 SHALL have port cts, input, 1, upstream request: v_data valid while high.
REQ-004 SHALL have port v_data, input, 4, upstream data word; must be stable while cts high.
REQ-005 SHALL have port rtr, output, 1, acknowledge to upstream (4-phase handshake).
REQ-006 SHALL have port rd_en, input, 1, consumer pop request.
REQ-007 SHALL have port rd_data, output, 4, FIFO head word; valid when empty low.
REQ-008 SHALL have ports empty, output, 1 and full, output, 1, FIFO status.
REQ-009 SHALL have port count, output, 3, FIFO occupancy 0..4.
REQ-010 SHALL have port rx_words, output, 8, total words accepted, wraps 255->0.
REQ-011 SHALL have port proto_err, output, 1, sticky handshake-violation flag.

Function
REQ-012 FSM states SHALL be IDLE, WAIT_SPACE, ACK.
REQ-013 IDLE: cts=1 and FIFO not full -> push v_data, rtr=1 next cycle, go ACK; cts=1 and full -> go WAIT_SPACE, latch v_data into hold register; cts=0 -> stay.
REQ-014 WAIT_SPACE: FIFO not full and cts=1 -> push held word, go ACK; cts=0 -> set proto_err, go IDLE, no push; v_data != held word -> set proto_err, stay.
REQ-015 ACK: rtr held 1 until cts sampled 0, then rtr=0 and go IDLE on the same edge.
REQ-016 Push latency SHALL be 1 cycle: word pushed at the edge cts=1 is first sampled in IDLE with space; rtr rises on that edge.
REQ-017 Exactly one push SHALL occur per handshake regardless of cts high duration.
REQ-018 FIFO SHALL be 4 deep, 4 bits wide, first-word fall-through: rd_data = head combinationally.
REQ-019 rd_en with empty=1 SHALL be ignored, no state change.
REQ-020 Simultaneous push and pop on full FIFO: pop SHALL take effect first; FSM in IDLE/WAIT_SPACE SHALL treat FIFO as not full that cycle; count unchanged.
REQ-021 Simultaneous push and pop on empty FIFO: pop ignored, push completes, count 0->1.
REQ-022 Read/write pointers SHALL be 2-bit, wrapping 3->0; count SHALL derive from a 3-bit occupancy register.
REQ-023 rx_words SHALL increment by 1 on every push, modulo 256.
REQ-024 proto_err SHALL stay 1 until reset.

Reset
REQ-025 reset=0 at an edge SHALL force: state IDLE, rtr=0, FIFO flushed, count=0, empty=1, full=0, rx_words=0, proto_err=0, hold register 0.
REQ-026 Reset mid-handshake (ACK or WAIT_SPACE) SHALL drop rtr the next edge and discard the in-flight word; upstream must restart from cts=0.
REQ-027 rd_data after reset SHALL be 0.

Structure
REQ-028 Shared package b10_link_pkg SHALL hold the state enum, FIFO_DEPTH=4, DATA_W=4, CNT_W=8.
REQ-029 FIFO SHALL be a separate sub-module b10_link_fifo; FSM, counter and error logic stay in b10_link_rx.

Verification
REQ-030 Single transfer: cts=1, v_data=4'hA from empty -> rtr=1 next cycle, count=1, rd_data=4'hA, rx_words=1; cts=0 -> rtr=0 next cycle.
REQ-031 Fill: 5 handshakes 1,2,3,4,5 with no reads -> full=1 after 4th, FSM in WAIT_SPACE, rtr=0; one rd_en pops 1 -> word 5 pushed next edge, rtr=1, count=4.
REQ-032 Withdrawal: full FIFO, cts=1 then cts=0 before space -> proto_err=1, count stays 4, rx_words unchanged.
REQ-033 Data change: WAIT_SPACE holding 4'h3, v_data changes to 4'h7 -> proto_err=1; after pop, held 4'h3 pushed.
REQ-034 Simultaneous push/pop at full: full FIFO, rd_en=1 with cts=1 -> count stays 4, head advances, rtr=1, no error.
REQ-035 Wrap and reset: 256 handshakes -> rx_words=0; reset=0 during ACK -> rtr=0, empty=1, proto_err=0 next cycle.
